// File: rtl/mem_stage_pipe.sv
// ----------------------------------------------------------------------------
// mem_stage_pipe
//
// Memory-access pipeline stage of the RV32 five-stage core. Owns the data
// memory, performs byte/halfword/word loads (sign or zero extended) and
// stores, stretches each memory access by WAIT_STATES stall cycles, flags
// misaligned accesses and holds the MEM/WB pipeline register.
//
// Parameters
//   XLEN         data/address width (only 32 is supported today)
//   DEPTH_WORDS  data memory depth in XLEN-bit words (power of two)
//   WAIT_STATES  extra cycles every load/store occupies (0..15)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   valid_m .. result_src_m   EX/MEM register contents (held while stall_m)
//   stall_m                   combinational stall request to upstream stages
//   *_w                       registered MEM/WB register contents
//
// Optional feature (macro MEM_DEBUG_PORT_EN)
//   dbg_addr / dbg_rdata      asynchronous word read port into the data
//                             memory, independent of the pipeline and stalls
// ----------------------------------------------------------------------------
module mem_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] write_data_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [4:0]      rd_m,
    input  logic            reg_write_m,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [1:0]      result_src_m,
    output logic            stall_m,
    output logic            valid_w,
    output logic            reg_write_w,
    output logic            misaligned_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] read_data_w,
    output logic [XLEN-1:0] pc_plus4_w,
    output logic [4:0]      rd_w,
    output logic [1:0]      result_src_w
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
    output logic [XLEN-1:0]                dbg_rdata
`endif
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam int         NB       = XLEN / 8;
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam bit         WS_ONE   = (WAIT_STATES == 1);
    localparam logic [3:0] WS_M1    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_done;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            w_memOp;
    logic            w_isHalf;
    logic            w_isWord;
    logic            w_misaligned;
    logic            w_access;
    logic [AW-1:0]   w_wordIdx;
    logic [XLEN-1:0] w_rdWord;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_loadData;
    logic [XLEN-1:0] w_storeWord;
    logic [NB-1:0]   w_byteEn;
    logic            w_unusedAddrBits;

    // The address bits above the memory index only wrap the address space.
    assign w_unusedAddrBits = ^alu_result_m[XLEN-1:AW+2];

    // Access decode. H and HU share funct3[1:0]=01, so both need addr[0]=0.
    assign w_memOp      = valid_m & (mem_read_m | mem_write_m);
    assign w_isHalf     = (funct3_m[1:0] == 2'b01);
    assign w_isWord     = (funct3_m == 3'b010);
    assign w_misaligned = w_memOp & ((w_isHalf & alu_result_m[0]) |
                                     (w_isWord & (alu_result_m[1:0] != 2'b00)));
    assign w_access     = w_memOp & ~w_misaligned;
    assign w_wordIdx    = alu_result_m[AW+1:2];
    assign w_rdWord     = r_mem[w_wordIdx];

    // Lane selection for loads, then sign or zero extension by funct3.
    assign w_byte = w_rdWord[{alu_result_m[1:0], 3'b000} +: 8];
    assign w_half = alu_result_m[1] ? w_rdWord[31:16] : w_rdWord[15:0];

    always_comb begin
        w_loadData = w_rdWord;
        case (funct3_m)
            3'b000:  w_loadData = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_loadData = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_loadData = {{(XLEN-16){1'b0}}, w_half};
            default: w_loadData = w_rdWord;
        endcase
    end

    // Store data is replicated across every lane so the byte enables alone
    // decide which bytes of the word get updated.
    always_comb begin
        w_storeWord = write_data_m;
        w_byteEn    = '1;
        case (funct3_m[1:0])
            2'b00: begin
                w_storeWord = {NB{write_data_m[7:0]}};
                w_byteEn    = NB'(1) << alu_result_m[1:0];
            end
            2'b01: begin
                w_storeWord = {(NB/2){write_data_m[15:0]}};
                w_byteEn    = alu_result_m[1] ? NB'(4'b1100) : NB'(4'b0011);
            end
            default: begin
                w_storeWord = write_data_m;
                w_byteEn    = '1;
            end
        endcase
    end

    // Stall request: the first cycle of an access stalls from IDLE, every
    // WAIT cycle stalls, and the cycle after WAIT (IDLE with done) completes.
    always_comb begin
        stall_m = 1'b0;
        if (HAS_WAIT) begin
            if (r_state == S_WAIT) begin
                stall_m = 1'b1;
            end else if (w_access && !r_done) begin
                stall_m = 1'b1;
            end
        end
    end

    // Wait-state sequencer. The IDLE cycle that starts an access already
    // counts as one stall cycle, so WAIT leaves when cnt reaches 1; that keeps
    // the total stall length at exactly WAIT_STATES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_done) begin
                        r_done <= 1'b0;
                    end else if (HAS_WAIT && w_access) begin
                        r_cnt <= WS_M1;
                        if (WS_ONE) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data memory. Deliberately not cleared by reset; a store lands only on
    // the completion edge and never in a cycle where reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && !stall_m && w_access && mem_write_m) begin
            for (int b = 0; b < NB; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_wordIdx][8*b +: 8] <= w_storeWord[8*b +: 8];
                end
            end
        end
    end

    // MEM/WB register: bubble while stalling, otherwise capture the
    // instruction. A misaligned access never writes the register file.
    always_ff @(posedge clk) begin
        if (rst || stall_m) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            misaligned_w <= 1'b0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            pc_plus4_w   <= '0;
            rd_w         <= 5'd0;
            result_src_w <= 2'd0;
        end else begin
            valid_w      <= valid_m;
            reg_write_w  <= reg_write_m & ~w_misaligned;
            misaligned_w <= w_misaligned;
            alu_result_w <= alu_result_m;
            read_data_w  <= (w_access && mem_read_m) ? w_loadData : '0;
            pc_plus4_w   <= pc_plus4_m;
            rd_w         <= rd_m;
            result_src_w <= result_src_m;
        end
    end

`ifdef MEM_DEBUG_PORT_EN
    assign dbg_rdata = r_mem[dbg_addr];
`else
    // No debug read port in this build.
`endif

endmodule
